mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Arbitrates the single 8-bit RAM/IO bus between instruction fetch (IF) and the data port (MEM).
//  Serialises each 1/2/4-byte access into byte cycles and reassembles read data.
//  Sits between the _if / mem pipeline stages and the cpu top-level mem_* pins.
//  Data port has priority; optional fairness lets a pending fetch go after every data access.
// PARAMETERS
//  FAIR     1        1: fetch wins the next arbitration after any data access if if_req is pending
//  ADDR_W   32       address width on all address ports
// PORTS
//  clk_in     in   1       system clock
//  rst_in     in   1       synchronous reset, active-low
//  rdy_in     in   1       low = pause: FSM, counters and outputs frozen, mem_wr forced 0
//  if_req     in   1       fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch byte address; always a 4-byte read
//  if_gnt     out  1       one-cycle pulse: if_data valid
//  if_data    out  32      assembled instruction; stable until next if_gnt
//  d_req      in   1       data request; held with d_we/d_len/d_addr/d_wdata until d_done
//  d_we       in   1       1 = write, 0 = read
//  d_len      in   2       0 = 1 byte, 1 = 2 bytes, 3 = 4 bytes (2 is illegal, treated as 4)
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   32      write data, byte k = d_wdata[8k+7:8k]
//  d_done     out  1       one-cycle pulse: access complete
//  d_rdata    out  32      read data, zero-extended; stable until next d_done
//  busy       out  1       FSM not in IDLE
//  mem_din    in   8       RAM/IO read byte
//  mem_dout   out  8       RAM/IO write byte
//  mem_a      out  ADDR_W  RAM/IO address
//  mem_wr     out  1       1 = write this cycle
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, fairness flag cleared. Reset mid-access aborts it;
//    no completion pulse; requesters re-issue.
//  FSM: IDLE -> RD | WR -> DONE -> IDLE.
//    DONE lasts exactly one cycle, so a requester dropping req after its pulse is never re-granted.
//  Arbitration: sampled only in IDLE. Requesters are d_req and if_req.
//    If d_req and (!if_req or !fair_flag): data wins.
//    Otherwise if if_req: fetch wins.
//    fair_flag is set at data completion when FAIR = 1 and if_req = 1; it is cleared at fetch grant.
//    Non-preemptive: the winner completes before re-arbitration.
//  Timing: cycle 0 is the IDLE cycle in which the grant is taken. N is the byte count.
//    Byte k uses address addr+k and is placed little-endian.
//  Read: mem_a = addr+k in cycle 1+k.
//    mem_din for byte k is captured at the end of cycle 2+k (2-cycle memory).
//    Pulse (if_gnt / d_done) is high in cycle N+2. Assembled data is registered in the same cycle.
//  Write: mem_wr = 1, mem_a = addr+k, mem_dout = byte k in cycle 1+k. d_done is high in cycle N+1.
//  Exactly N bus cycles per access: no speculative or repeated reads.
//    Mandatory for IO (addr[17:16] = 2'b11); a 0x30000 read consumes exactly one input byte.
//  Outside a write byte cycle: mem_wr = 0, mem_dout = 0. mem_a holds the last value.
//  rdy_in low: state, byte counter and captured bytes hold; mem_wr = 0; no pulse is generated.
//    A read whose capture cycle is paused captures on the first cycle rdy_in is high again.
//  Byte counter is 2 bits. Address increments use the full ADDR_W add.
//    Wrap past 2^ADDR_W - 1 is modular, with no error.
//  Simultaneous d_req and if_req in IDLE with fair_flag = 0: data first, fetch next.
// STRUCTURE
//  Shared defines header holds: d_len encodings, FSM state codes, IO region constant 2'b11,
//  and the byte-count decode.
//  One natural sub-module: mem_byte_seq, containing the byte counter, address increment,
//  and read-byte assembly shift register. Arbitration and FSM stay in the top module.
// TESTING
//  1. Fetch 0x1000 with mem bytes 13,05,00,00: mem_a 1000..1003 in cycles 1-4, if_gnt in cycle 6,
//     if_data = 0x00000513.
//  2. Store word 0xDEADBEEF to 0x200: mem_wr high in cycles 1-4 with dout EF,BE,AD,DE;
//     d_done in cycle 5.
//  3. d_req and if_req together, FAIR = 1: data serviced first, fetch next, then data again.
//     Neither requester waits for more than one foreign access.
//  4. d_len = 0 read of 0x30000: exactly one bus read at 0x30000; d_rdata = 0x000000xx.
//  5. rdy_in low for 3 cycles during byte 2 of a fetch: the bus freezes, no mem_wr,
//     and data is correct with if_gnt delayed by 3 cycles.
//  6. rst_in low in cycle 2 of a 4-byte write: mem_wr = 0 next cycle, no d_done,
//     FSM = IDLE, busy = 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the 8-bit memory bus arbiter:
//   - FSM state codes and bus owner encoding
//   - d_len encodings and the byte-count decode (last byte index)
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    // Index of the last byte of an access (byte count - 1).
    // The unused encoding 2'd2 is treated as a full word.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] len);
        logic [1:0] idx;
        case (len)
            LEN_BYTE: idx = 2'd0;
            LEN_HALF: idx = 2'd1;
            LEN_WORD: idx = 2'd3;
            default:  idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_byte_seq.sv
// Byte sequencer for the 8-bit memory bus.
// Holds the 2-bit byte counter, the bus address register (full-width
// modular increment) and the read-data assembly register.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   rdy             low = freeze all state
//   load            start a new access at load_addr (clears assembly)
//   load_addr       first byte address
//   last_idx        index of last byte of the current access
//   rd_step         FSM is in the read state
//   wr_step         FSM is in the write state
//   mem_din         read byte from memory
//   mem_a           bus address (registered)
//   cnt             index of byte currently on the bus
//   last            cnt is the last byte of the access
//   tail            read: all addresses issued, final byte being captured
//   asm_next        assembled read word including this cycle's capture
module mem_byte_seq
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [1:0]        last_idx,
    input  logic              rd_step,
    input  logic              wr_step,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic [1:0]        cnt,
    output logic              last,
    output logic              tail,
    output logic [31:0]       asm_next
);

    logic [31:0] asm_q;
    logic        cap_vld;
    logic [1:0]  cap_idx;

    assign last = (cnt == last_idx);

    // With a 2-cycle memory the byte returned in a read cycle belongs to
    // the address issued one cycle earlier: capture lags issue by one.
    // The extra tail cycle captures the final byte without issuing a new
    // address, so the bus never sees a speculative read.
    assign cap_vld = rd_step && (tail || (cnt != 2'd0));
    assign cap_idx = tail ? cnt : (cnt - 2'd1);

    always_comb begin
        asm_next = asm_q;
        if (cap_vld) begin
            asm_next[{cap_idx, 3'b000} +: 8] = mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_a <= '0;
            cnt   <= '0;
            tail  <= 1'b0;
            asm_q <= '0;
        end else if (rdy) begin
            if (load) begin
                mem_a <= load_addr;
                cnt   <= '0;
                tail  <= 1'b0;
                asm_q <= '0;
            end else if (wr_step) begin
                if (!last) begin
                    cnt   <= cnt + 2'd1;
                    mem_a <= mem_a + ADDR_W'(1);
                end
            end else if (rd_step) begin
                asm_q <= asm_next;
                if (!tail) begin
                    if (last) begin
                        tail <= 1'b1;
                    end else begin
                        cnt   <= cnt + 2'd1;
                        mem_a <= mem_a + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single 8-bit RAM/IO bus shared by instruction fetch and
// the data port. Serialises 1/2/4-byte accesses into byte cycles and
// reassembles read data little-endian. Data port has priority; with FAIR
// a pending fetch goes after every data access.
// Ports:
//   clk_in, rst_in   clock, synchronous active-low reset
//   rdy_in           low = pause (state frozen, mem_wr forced 0, no pulses)
//   if_req/if_addr   fetch request (4-byte read); if_gnt pulse, if_data word
//   d_req/d_we/d_len/d_addr/d_wdata   data request; d_done pulse, d_rdata
//   busy             FSM not idle
//   mem_din/mem_dout/mem_a/mem_wr     byte-wide RAM/IO bus
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit          FAIR   = 1'b1,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_len,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              busy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    state_t      state_q, state_d;
    owner_t      owner_q;
    logic [1:0]  last_q;
    logic [31:0] wdata_q;
    logic        fair_q;

    logic        grant_d, grant_f;
    logic        rd_fin, done_fire;
    logic [1:0]  cnt;
    logic        last, tail;
    logic [31:0] asm_next;

    mem_byte_seq #(
        .ADDR_W(ADDR_W)
    ) u_seq (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .rdy      (rdy_in),
        .load     (grant_d | grant_f),
        .load_addr(grant_d ? d_addr : if_addr),
        .last_idx (last_q),
        .rd_step  (state_q == ST_RD),
        .wr_step  (state_q == ST_WR),
        .mem_din  (mem_din),
        .mem_a    (mem_a),
        .cnt      (cnt),
        .last     (last),
        .tail     (tail),
        .asm_next (asm_next)
    );

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        rd_fin    = 1'b0;
        done_fire = 1'b0;
        if_gnt    = 1'b0;
        d_done    = 1'b0;
        mem_wr    = 1'b0;
        mem_dout  = '0;
        case (state_q)
            ST_IDLE: begin
                if (rdy_in) begin
                    if (d_req && (!if_req || !fair_q)) begin
                        grant_d = 1'b1;
                        state_d = d_we ? ST_WR : ST_RD;
                    end else if (if_req) begin
                        grant_f = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (rdy_in && tail) begin
                    rd_fin  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR: begin
                if (rdy_in) begin
                    mem_wr   = 1'b1;
                    mem_dout = wdata_q[{cnt, 3'b000} +: 8];
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (rdy_in) begin
                    done_fire = 1'b1;
                    if (owner_q == OWN_FETCH) begin
                        if_gnt = 1'b1;
                    end else begin
                        d_done = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Keep the bus quiet while reset is asserted, before the state
        // register has been cleared by the clock edge.
        if (!rst_in) begin
            if_gnt   = 1'b0;
            d_done   = 1'b0;
            mem_wr   = 1'b0;
            mem_dout = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            owner_q <= OWN_FETCH;
            last_q  <= '0;
            wdata_q <= '0;
            fair_q  <= 1'b0;
            if_data <= '0;
            d_rdata <= '0;
        end else if (rdy_in) begin
            if (grant_d) begin
                owner_q <= OWN_DATA;
                last_q  <= last_byte_idx(d_len);
                wdata_q <= d_wdata;
            end
            if (grant_f) begin
                owner_q <= OWN_FETCH;
                last_q  <= last_byte_idx(LEN_WORD);
                fair_q  <= 1'b0;
            end
            // Result registers load as the final byte is captured so the
            // word is already valid in the pulse cycle.
            if (rd_fin) begin
                if (owner_q == OWN_FETCH) begin
                    if_data <= asm_next;
                end else begin
                    d_rdata <= asm_next;
                end
            end
            if (done_fire && (owner_q == OWN_DATA) && FAIR && if_req) begin
                fair_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic [31:0] if_data;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_len;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        busy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(
        .FAIR  (1'b1),
        .ADDR_W(32)
    ) dut (
        .clk_in  (clk),
        .rst_in  (rst_n),
        .rdy_in  (rdy_in),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_gnt  (if_gnt),
        .if_data (if_data),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_len   (d_len),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .busy    (busy),
        .mem_din (mem_din),
        .mem_dout(mem_dout),
        .mem_a   (mem_a),
        .mem_wr  (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2-cycle memory model: address of cycle t returns data in cycle t+1.
    // The whole bus, memory included, freezes while rdy_in is low.
    logic [7:0] ram [0:262143];
    bit loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
            ram[18'h01000] <= 8'h13; ram[18'h01001] <= 8'h05;
            ram[18'h01004] <= 8'h93; ram[18'h01005] <= 8'h00;
            ram[18'h01006] <= 8'h10; ram[18'h01007] <= 8'h00;
            ram[18'h30000] <= 8'h5A;
            ram[18'h3FFFE] <= 8'h11; ram[18'h3FFFF] <= 8'h22;
            ram[18'h00000] <= 8'h33; ram[18'h00001] <= 8'h44;
            loaded  <= 1'b1;
            mem_din <= 8'h00;
        end else if (rdy_in) begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_cyc;
        int          p;
        int          l;
    } vec_t;

    // One access: request in cycle 0, per-cycle bus checks, pulse cycle,
    // result word. rdy_in is dropped in cycles p..p+l-1 when l != 0.
    task automatic run_access(input int id, input vec_t v);
        int n, got, e, foreign;
        logic [31:0] sh, exp_a;
        bit rdy_s, pulse;
        n = v.fetch ? 4 : (v.len == 2'd0 ? 1 : (v.len == 2'd1 ? 2 : 4));
        got = 0;
        foreign = 0;
        @(negedge clk);
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_len = v.len; d_addr = v.addr; d_wdata = v.wdata;
        end
        for (int c = 1; c <= 40 && got == 0; c++) begin
            @(negedge clk);
            rdy_s = rdy_in;
            e = (c <= v.p) ? c : ((c <= v.p + v.l) ? v.p : c - v.l);
            pulse = v.fetch ? if_gnt : d_done;
            if (v.fetch ? d_done : if_gnt) foreign++;
            if (pulse) begin
                got = c;
                if_req = 1'b0;
                d_req = 1'b0;
            end else begin
                chk($sformatf("v%0d c%0d busy", id, c), {31'd0, busy}, 32'd1);
                if (v.we && rdy_s && e <= n) begin
                    exp_a = v.addr + 32'(e - 1);
                    sh = v.wdata >> (8 * (e - 1));
                    chk($sformatf("v%0d c%0d mem_wr", id, c), {31'd0, mem_wr}, 32'd1);
                    chk($sformatf("v%0d c%0d mem_a", id, c), mem_a, exp_a);
                    chk($sformatf("v%0d c%0d mem_dout", id, c), {24'd0, mem_dout}, {24'd0, sh[7:0]});
                end else begin
                    chk($sformatf("v%0d c%0d mem_wr", id, c), {31'd0, mem_wr}, 32'd0);
                    chk($sformatf("v%0d c%0d mem_dout", id, c), {24'd0, mem_dout}, 32'd0);
                    if (!v.we && e >= 1 && e <= n + 1) begin
                        exp_a = v.addr + 32'(((e <= n) ? e : n) - 1);
                        chk($sformatf("v%0d c%0d mem_a", id, c), mem_a, exp_a);
                    end
                end
            end
            if (v.l != 0 && c == v.p) rdy_in = 1'b0;
            if (v.l != 0 && c == v.p + v.l) rdy_in = 1'b1;
        end
        if_req = 1'b0;
        d_req = 1'b0;
        rdy_in = 1'b1;
        chk($sformatf("v%0d pulse_cycle", id), got, v.exp_cyc);
        chk($sformatf("v%0d foreign_pulse", id), foreign, 32'd0);
        if (!v.we) begin
            chk($sformatf("v%0d data", id), v.fetch ? if_data : d_rdata, v.exp_data);
        end
        @(negedge clk);
        chk($sformatf("v%0d idle_after", id), {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[16];

    initial begin
        int t1, t2, t3, nd, ndone;

        vecs[0]  = '{1'b1, 1'b0, 2'd3, 32'h0000_1000, 32'h0,         32'h0000_0513, 6, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 2'd3, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         5, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0201, 32'h0,         32'h0000_ADBE, 4, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'h0,         32'h0000_00DE, 3, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 32'h0003_0000, 32'h0,         32'h0000_005A, 3, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0300, 32'hFFFF_1234, 32'h0,         3, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0300, 32'h0,         32'h0000_1234, 6, 0, 0};
        vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'h0000_0513, 6, 0, 0};
        vecs[9]  = '{1'b0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,         32'h4433_2211, 6, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 32'h0000_1004, 32'h0,         32'h0010_0093, 6, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 2'd3, 32'h0000_1000, 32'h0,         32'h0000_0513, 9, 3, 3};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 32'h0000_0203, 32'h7777_77A5, 32'h0,         2, 0, 0};
        vecs[13] = '{1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0,         32'hA5AD_BEEF, 6, 0, 0};
        vecs[14] = '{1'b0, 1'b1, 2'd3, 32'h0000_0204, 32'h0102_0304, 32'h0,         7, 2, 2};
        vecs[15] = '{1'b0, 1'b0, 2'd3, 32'h0000_0204, 32'h0,         32'h0102_0304, 6, 0, 0};

        rst_n = 1'b0; rdy_in = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_len = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst busy",     {31'd0, busy},    32'd0);
        chk("rst if_gnt",   {31'd0, if_gnt},  32'd0);
        chk("rst d_done",   {31'd0, d_done},  32'd0);
        chk("rst mem_wr",   {31'd0, mem_wr},  32'd0);
        chk("rst mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst mem_a",    mem_a,            32'd0);
        chk("rst if_data",  if_data,          32'd0);
        chk("rst d_rdata",  d_rdata,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_access(i, vecs[i]);
        end

        // Both requesters at once with FAIR: data, fetch, data again.
        // ram[0x200..0x203] = EF BE AD A5 after the table.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_len = 2'd3; d_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h1000;
        t1 = 0; t2 = 0; t3 = 0; nd = 0;
        for (int c = 1; c <= 60 && nd < 2; c++) begin
            @(negedge clk);
            if (d_done) begin
                nd++;
                if (nd == 1) t1 = c;
                else begin t3 = c; d_req = 1'b0; end
            end
            if (if_gnt) begin
                t2 = c; if_req = 1'b0;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        chk("fair first d_done", t1, 32'd6);
        chk("fair if_gnt",       t2, 32'd13);
        chk("fair second d_done", t3, 32'd20);
        chk("fair if_data",  if_data, 32'h0000_0513);
        chk("fair d_rdata",  d_rdata, 32'hA5AD_BEEF);
        @(negedge clk);

        // Reset in cycle 2 of a word write.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_len = 2'd3; d_addr = 32'h400; d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rstmid c1 mem_wr", {31'd0, mem_wr}, 32'd1);
        @(negedge clk);
        chk("rstmid c2 mem_a", mem_a, 32'h401);
        rst_n = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk("rstmid c3 mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rstmid c3 busy",   {31'd0, busy},   32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (d_done || if_gnt) ndone++;
            if (c == 0) begin
                chk("rstmid c4 busy",   {31'd0, busy},   32'd0);
                chk("rstmid c4 mem_wr", {31'd0, mem_wr}, 32'd0);
                chk("rstmid c4 mem_a",  mem_a,           32'd0);
            end
        end
        chk("rstmid pulses", ndone, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
